// File: rtl/sccb_defs.sv
// Shared SCCB responder definitions: FSM state encoding, bus-level constants
// and the default device ID.
package sccb_defs;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ID,
        ST_ID_ACK,
        ST_SUB,
        ST_SUB_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RACK,
        ST_WAIT_STOP
    } sccb_state_t;

    localparam logic [7:0] SCCB_DEF_DEV_ID = 8'h42;
    localparam logic       SCCB_ACK        = 1'b0;
    localparam logic       SCCB_NACK       = 1'b1;

    // START: SDA falls while SCL is high.
    function automatic logic sccb_is_start(input logic scl_lvl, input logic sda_fall);
        return scl_lvl & sda_fall;
    endfunction

    // STOP: SDA rises while SCL is high.
    function automatic logic sccb_is_stop(input logic scl_lvl, input logic sda_rise);
        return scl_lvl & sda_rise;
    endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Multi-flop synchronizer for one asynchronous bus line, with rise/fall
// detection on the synchronized level. Flops reset to 1 (idle bus level).
module sccb_line_sync #(
    parameter int SYNC_LEN = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_LEN-1:0] sync_q;
    logic                prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], d_i};
            prev_q <= sync_q[SYNC_LEN-1];
        end
    end

    assign level_o = sync_q[SYNC_LEN-1];
    assign rise_o  = sync_q[SYNC_LEN-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_LEN-1] & prev_q;

endmodule

// File: rtl/sccb_slave_regs.sv
// SCCB/I2C write responder backed by a 256x8 register file, with write strobe
// and debug read port. Define SCCB_SLAVE_READ_EN to add the register read path.
module sccb_slave_regs
    import sccb_defs::*;
#(
    parameter logic [7:0] DEV_ID   = SCCB_DEF_DEV_ID,
    parameter int         SYNC_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    sccb_line_sync #(.SYNC_LEN(SYNC_LEN)) u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (scl_i),
        .level_o (scl_s),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    sccb_line_sync #(.SYNC_LEN(SYNC_LEN)) u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (sda_i),
        .level_o (sda_s),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    sccb_state_t state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        busy_q, busy_d;
    logic        oe_q, oe_d;
    logic        ack_ph_q, ack_ph_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we;
    logic [7:0]  regs_q [256];

    logic       start_w, stop_w, id_match;
    logic [7:0] byte_w;

    assign start_w = sccb_is_start(scl_s, sda_fall);
    assign stop_w  = sccb_is_stop(scl_s, sda_rise);
    assign byte_w  = {shift_q, sda_s};

`ifdef SCCB_SLAVE_READ_EN
    logic       rw_q, rw_d;
    logic [7:0] rd_byte;
    assign rd_byte  = regs_q[ptr_q];
    assign id_match = (byte_w[7:1] == DEV_ID[7:1]);
`else
    // Without the read path a read ID is simply not ours.
    assign id_match = (byte_w[7:1] == DEV_ID[7:1]) && (byte_w[0] == 1'b0);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        oe_d     = oe_q;
        ack_ph_d = ack_ph_q;
        strobe_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        we       = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
        rw_d     = rw_q;
`endif
        if (start_w) begin
            state_d  = ST_ID;
            cnt_d    = 3'd0;
            oe_d     = 1'b0;
            ack_ph_d = 1'b0;
        end else if (stop_w) begin
            state_d  = ST_IDLE;
            cnt_d    = 3'd0;
            oe_d     = 1'b0;
            busy_d   = 1'b0;
            ack_ph_d = 1'b0;
        end else begin
            case (state_q)
                ST_ID: if (scl_rise) begin
                    shift_d = byte_w[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (id_match) begin
                            state_d  = ST_ID_ACK;
                            busy_d   = 1'b1;
                            ack_ph_d = 1'b0;
`ifdef SCCB_SLAVE_READ_EN
                            rw_d     = byte_w[0];
`endif
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                // Ack slot: pull low on the first SCL fall, release on the second.
                ST_ID_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        oe_d     = 1'b1;
                        ack_ph_d = 1'b1;
                    end else begin
                        ack_ph_d = 1'b0;
                        cnt_d    = 3'd0;
                        oe_d     = 1'b0;
                        state_d  = ST_SUB;
`ifdef SCCB_SLAVE_READ_EN
                        if (rw_q) begin
                            shift_d = rd_byte[6:0];
                            oe_d    = ~rd_byte[7];
                            state_d = ST_RDATA;
                        end
`endif
                    end
                end
                ST_SUB: if (scl_rise) begin
                    shift_d = byte_w[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ptr_d    = byte_w;
                        state_d  = ST_SUB_ACK;
                        ack_ph_d = 1'b0;
                    end
                end
                ST_SUB_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        oe_d     = 1'b1;
                        ack_ph_d = 1'b1;
                    end else begin
                        oe_d     = 1'b0;
                        ack_ph_d = 1'b0;
                        cnt_d    = 3'd0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift_d = byte_w[6:0];
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        we       = 1'b1;
                        strobe_d = 1'b1;
                        waddr_d  = ptr_q;
                        wdata_d  = byte_w;
                        ptr_d    = ptr_q + 8'd1;
                        state_d  = ST_WDATA_ACK;
                        ack_ph_d = 1'b0;
                    end
                end
`ifdef SCCB_SLAVE_READ_EN
                // Bit 7 went out when the ack slot ended; each fall here shifts the next.
                ST_RDATA: if (scl_fall) begin
                    if (cnt_q == 3'd7) begin
                        oe_d     = 1'b0;
                        cnt_d    = 3'd0;
                        ack_ph_d = 1'b0;
                        state_d  = ST_RACK;
                    end else begin
                        oe_d    = ~shift_q[6];
                        shift_d = {shift_q[5:0], 1'b0};
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
                ST_RACK: begin
                    if (scl_rise) begin
                        if (sda_s == SCCB_NACK) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            ptr_d    = ptr_q + 8'd1;
                            ack_ph_d = 1'b1;
                        end
                    end else if (scl_fall && ack_ph_q) begin
                        shift_d  = rd_byte[6:0];
                        oe_d     = ~rd_byte[7];
                        cnt_d    = 3'd0;
                        ack_ph_d = 1'b0;
                        state_d  = ST_RDATA;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            shift_q  <= 7'd0;
            ptr_q    <= 8'd0;
            busy_q   <= 1'b0;
            oe_q     <= 1'b0;
            ack_ph_q <= 1'b0;
            strobe_q <= 1'b0;
            waddr_q  <= 8'd0;
            wdata_q  <= 8'd0;
`ifdef SCCB_SLAVE_READ_EN
            rw_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            oe_q     <= oe_d;
            ack_ph_q <= ack_ph_d;
            strobe_q <= strobe_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
`ifdef SCCB_SLAVE_READ_EN
            rw_q     <= rw_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
        end else if (we) begin
            regs_q[waddr_d] <= wdata_d;
        end
    end

    assign sda_oe    = oe_q;
    assign busy      = busy_q;
    assign wr_strobe = strobe_q;
    assign wr_addr   = waddr_q;
    assign wr_data   = wdata_q;
    assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: tb/tb_sccb_slave_regs.sv
// Randomized self-checking bench for sccb_slave_regs: a bus master model drives
// SCCB transactions, a register-file/strobe reference model predicts results.
module tb_sccb_slave_regs;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] wr_addr, wr_data, dbg_addr, dbg_data;

    int total = 0;
    int bad   = 0;
    int qtr   = 12;

    logic [15:0] strb_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  mdl [256];
    logic [7:0]  wbuf [8];
    bit          long_pulse = 1'b0;
    bit          oe_seen = 1'b0;
    logic        prev_strb = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    sccb_slave_regs #(.DEV_ID(8'h42), .SYNC_LEN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strb_q.push_back({wr_addr, wr_data});
        if (wr_strobe && prev_strb) long_pulse = 1'b1;
        if (sda_oe) oe_seen = 1'b1;
        prev_strb = wr_strobe;
    end

    initial begin
        #4_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    // ---------------- bus master ----------------
    task automatic hw(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; hw(qtr);
        scl_m = 1'b1; hw(qtr);
        sda_m = 1'b0; hw(qtr);
        scl_m = 1'b0; hw(qtr);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; hw(qtr);
        scl_m = 1'b1; hw(qtr);
        sda_m = 1'b1; hw(qtr);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    hw(qtr);
        scl_m = 1'b1; hw(2 * qtr);
        scl_m = 1'b0; hw(qtr);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic nack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; hw(qtr);
        scl_m = 1'b1; hw(qtr);
        nack = sda_line; hw(qtr);
        scl_m = 1'b0; hw(qtr);
    endtask

    task automatic recv_byte(input logic nack_in, output logic [7:0] b);
        b = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hw(qtr);
            scl_m = 1'b1; hw(qtr);
            b = {b[6:0], sda_line}; hw(qtr);
            scl_m = 1'b0;
        end
        hw(qtr);
        sda_m = nack_in; hw(qtr);
        scl_m = 1'b1; hw(2 * qtr);
        scl_m = 1'b0; hw(qtr);
        sda_m = 1'b1;
    endtask

    task automatic bus_write(input logic [7:0] id, input logic [7:0] sub, input int n,
                             output logic [5:0] nk);
        logic b;
        nk = '0;
        bus_start();
        send_byte(id, b);  nk[0] = b;
        send_byte(sub, b); nk[1] = b;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], b);
            nk[i + 2] = b;
        end
        bus_stop();
        hw(4);
    endtask

    // Reference: a matching write ID acks every byte and stores data at
    // consecutive 8-bit addresses starting at sub; anything else is ignored.
    task automatic model_write(input logic [7:0] id, input logic [7:0] sub, input int n,
                               output logic [5:0] exp_nk);
        int p;
        if (id == 8'h42) begin
            exp_nk = '0;
            p = sub;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({p[7:0], wbuf[i]});
                mdl[p % 256] = wbuf[i];
                p = (p + 1) % 256;
            end
        end else begin
            exp_nk = 6'((1 << (n + 2)) - 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        hw(5);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (wr_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
        total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 8'($urandom);
            #1;
            total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL reset_reg[%h] got=%h exp=00", dbg_addr, dbg_data); end
        end
    endtask

    task automatic test_single_write();
        logic n0, n1, n2;
        qtr = 62;
        strb_q.delete();
        bus_start();
        send_byte(8'h42, n0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        send_byte(8'h12, n1);
        send_byte(8'h80, n2);
        bus_stop();
        hw(4);
        qtr = 12;
        total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL single_acks got=%b exp=000", {n0, n1, n2}); end
        total++; if (strb_q.size() != 1) begin bad++; $display("FAIL single_nstrobe got=%0d exp=1", strb_q.size()); end
        else begin
            total++; if (strb_q[0] !== 16'h1280) begin bad++; $display("FAIL single_strobe got=%h exp=1280", strb_q[0]); end
        end
        dbg_addr = 8'h12; #1;
        total++; if (dbg_data !== 8'h80) begin bad++; $display("FAIL single_reg12 got=%h exp=80", dbg_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_stop got=%b exp=0", busy); end
        mdl[8'h12] = 8'h80;
    endtask

    task automatic test_burst_wrap();
        logic b;
        logic [5:0]  nk;
        logic [15:0] want [3];
        want[0] = 16'hFE11; want[1] = 16'hFF22; want[2] = 16'h0033;
        strb_q.delete();
        nk = '0;
        bus_start();
        send_byte(8'h42, b); nk[0] = b;
        send_byte(8'hFE, b); nk[1] = b;
        send_byte(8'h11, b); nk[2] = b;
        send_byte(8'h22, b); nk[3] = b;
        send_byte(8'h33, b); nk[4] = b;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL burst_busy got=%b exp=1", busy); end
        bus_stop();
        hw(4);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL burst_busy_stop got=%b exp=0", busy); end
        total++; if (nk !== 6'b0) begin bad++; $display("FAIL burst_acks got=%b exp=000000", nk); end
        total++; if (strb_q.size() != 3) begin bad++; $display("FAIL burst_nstrobe got=%0d exp=3", strb_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (strb_q[i] !== want[i]) begin bad++; $display("FAIL burst_strobe%0d got=%h exp=%h", i, strb_q[i], want[i]); end
            end
        end
        mdl[8'hFE] = 8'h11; mdl[8'hFF] = 8'h22; mdl[8'h00] = 8'h33;
        dbg_addr = 8'h00; #1;
        total++; if (dbg_data !== 8'h33) begin bad++; $display("FAIL burst_reg00 got=%h exp=33", dbg_data); end
    endtask

    task automatic test_wrong_id();
        logic [5:0] nk;
        strb_q.delete();
        wbuf[0] = 8'h5A;
        @(negedge clk); oe_seen = 1'b0;
        bus_write(8'h40, 8'h12, 1, nk);
        total++; if (nk[2:0] !== 3'b111) begin bad++; $display("FAIL wrongid_acks got=%b exp=111", nk[2:0]); end
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL wrongid_oe got=%b exp=0", oe_seen); end
        total++; if (strb_q.size() != 0) begin bad++; $display("FAIL wrongid_nstrobe got=%0d exp=0", strb_q.size()); end
        dbg_addr = 8'h12; #1;
        total++; if (dbg_data !== mdl[8'h12]) begin bad++; $display("FAIL wrongid_reg12 got=%h exp=%h", dbg_data, mdl[8'h12]); end
    endtask

    task automatic test_abort();
        logic b0, b1;
        strb_q.delete();
        bus_start();
        send_byte(8'h42, b0);
        send_byte(8'h12, b1);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop();
        hw(4);
        total++; if (strb_q.size() != 0) begin bad++; $display("FAIL abort_nstrobe got=%0d exp=0", strb_q.size()); end
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL abort_sda_oe got=%b exp=0", sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
        dbg_addr = 8'h12; #1;
        total++; if (dbg_data !== mdl[8'h12]) begin bad++; $display("FAIL abort_reg12 got=%h exp=%h", dbg_data, mdl[8'h12]); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] nk;
        int waited;
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h42 >> i));
        sda_m = 1'b1;
        waited = 0;
        while (sda_oe !== 1'b1 && waited < 50) begin
            @(posedge clk); waited++;
        end
        total++; if (sda_oe !== 1'b1) begin bad++; $display("FAIL rstmid_ack_drive got=%b exp=1", sda_oe); end
        #7 rst = 1'b1;
        #1;
        total++; if (sda_oe !== 1'b0) begin bad++; $display("FAIL rstmid_sda_oe got=%b exp=0", sda_oe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        hw(3);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        dbg_addr = 8'h12; #1;
        total++; if (dbg_data !== 8'h00) begin bad++; $display("FAIL rstmid_reg12 got=%h exp=00", dbg_data); end
        strb_q.delete();
        scl_m = 1'b1; hw(qtr);
        wbuf[0] = 8'hAA;
        bus_write(8'h42, 8'h05, 1, nk);
        total++; if (nk[2:0] !== 3'b000) begin bad++; $display("FAIL rstmid_acks got=%b exp=000", nk[2:0]); end
        total++; if (strb_q.size() != 1) begin bad++; $display("FAIL rstmid_nstrobe got=%0d exp=1", strb_q.size()); end
        else begin
            total++; if (strb_q[0] !== 16'h05AA) begin bad++; $display("FAIL rstmid_strobe got=%h exp=05AA", strb_q[0]); end
        end
        dbg_addr = 8'h05; #1;
        total++; if (dbg_data !== 8'hAA) begin bad++; $display("FAIL rstmid_reg05 got=%h exp=AA", dbg_data); end
        mdl[8'h05] = 8'hAA;
    endtask

    task automatic test_random();
        logic [7:0] id, sub;
        logic [5:0] nk, exp_nk;
        int n;
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(3) == 0) begin
                do id = 8'($urandom); while (id[7:1] == 7'h21);
            end else begin
                id = 8'h42;
            end
            sub = 8'($urandom);
            n = $urandom_range(4, 1);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            strb_q.delete();
            exp_q.delete();
            model_write(id, sub, n, exp_nk);
            bus_write(id, sub, n, nk);
            total++; if (nk !== exp_nk) begin bad++; $display("FAIL rand%0d_acks id=%h got=%b exp=%b", it, id, nk, exp_nk); end
            total++; if (strb_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_nstrobe got=%0d exp=%0d", it, strb_q.size(), exp_q.size()); end
            else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++; if (strb_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_strobe%0d got=%h exp=%h", it, i, strb_q[i], exp_q[i]); end
                end
            end
            for (int k = 0; k < 2; k++) begin
                dbg_addr = (k == 0) ? sub : 8'($urandom);
                #1;
                total++; if (dbg_data !== mdl[dbg_addr]) begin bad++; $display("FAIL rand%0d_reg[%h] got=%h exp=%h", it, dbg_addr, dbg_data, mdl[dbg_addr]); end
            end
        end
        total++; if (long_pulse !== 1'b0) begin bad++; $display("FAIL strobe_width got=multi-cycle exp=single"); end
    endtask

    task automatic test_read();
        logic       n0, n1, n2;
        logic [5:0] nk, exp_nk;
`ifdef SCCB_SLAVE_READ_EN
        logic [7:0] r0, r1;
        wbuf[0] = 8'hC3; wbuf[1] = 8'h3C;
        exp_q.delete();
        model_write(8'h42, 8'h12, 2, exp_nk);
        bus_write(8'h42, 8'h12, 2, nk);
        total++; if (nk !== exp_nk) begin bad++; $display("FAIL read_prep_acks got=%b exp=%b", nk, exp_nk); end
        strb_q.delete();
        bus_start();
        send_byte(8'h42, n0);
        send_byte(8'h12, n1);
        bus_start();
        send_byte(8'h43, n2);
        recv_byte(1'b0, r0);
        recv_byte(1'b1, r1);
        bus_stop();
        hw(4);
        total++; if ({n0, n1, n2} !== 3'b000) begin bad++; $display("FAIL read_acks got=%b exp=000", {n0, n1, n2}); end
        total++; if (r0 !== mdl[8'h12]) begin bad++; $display("FAIL read_byte0 got=%h exp=%h", r0, mdl[8'h12]); end
        total++; if (r1 !== mdl[8'h13]) begin bad++; $display("FAIL read_byte1 got=%h exp=%h", r1, mdl[8'h13]); end
        total++; if (strb_q.size() != 0) begin bad++; $display("FAIL read_nstrobe got=%0d exp=0", strb_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL read_busy got=%b exp=0", busy); end
`else
        nk = '0; exp_nk = '0;
        strb_q.delete();
        bus_start();
        send_byte(8'h42, n0);
        send_byte(8'h12, n1);
        bus_start();
        @(negedge clk); oe_seen = 1'b0;
        send_byte(8'h43, n2);
        total++; if (oe_seen !== 1'b0) begin bad++; $display("FAIL readid_oe got=%b exp=0", oe_seen); end
        bus_stop();
        hw(4);
        total++; if ({n0, n1, n2} !== 3'b001) begin bad++; $display("FAIL readid_acks got=%b exp=001", {n0, n1, n2}); end
        total++; if (strb_q.size() != 0) begin bad++; $display("FAIL readid_nstrobe got=%0d exp=0", strb_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL readid_busy got=%b exp=0", busy); end
        total++; if (nk !== exp_nk) begin bad++; $display("FAIL readid_state got=%b exp=%b", nk, exp_nk); end
`endif
    endtask

    initial begin
        dbg_addr = 8'h00;
        for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
        test_reset();
        test_single_write();
        test_burst_wrap();
        test_wrong_id();
        test_abort();
        test_reset_mid();
        test_random();
        test_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
